// File: rtl/store_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : store_buffer                                                     |
// | Brief   : Aligns and queues stores, drains them to data memory over a      |
// |           valid/ready port, and flags loads that hit a pending word.       |
// |           Optional tail merging is enabled by STORE_BUFFER_MERGE_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [31:0]              st_data,
  input  logic [3:0]               st_we,
  output logic                     mem_req,
  input  logic                     mem_ready,
  output logic [ADDR_W-3:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_we,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_conflict,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-3:0] r_addr [DEPTH];
  logic [31:0]       r_data [DEPTH];
  logic [3:0]        r_we   [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [31:0]       w_aligned;
  logic              w_full;
  logic              w_store;
  logic              w_alloc;
  logic              w_pop;
  logic              w_merge;

  // Replicate the store value into every lane so the byte mask alone selects it.
  always_comb begin
    w_aligned = st_data;
    case (st_we)
      4'b1100, 4'b0011:                   w_aligned = {2{st_data[15:0]}};
      4'b1000, 4'b0100, 4'b0010, 4'b0001: w_aligned = {4{st_data[7:0]}};
      default:                            w_aligned = st_data;
    endcase
  end

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_store = st_valid && (st_we != 4'b0000);
  assign w_pop   = (r_count != '0) && mem_ready;

`ifdef STORE_BUFFER_MERGE_EN
  logic [PTR_W-1:0] w_tail_last;
  assign w_tail_last = r_tail - PTR_W'(1);
  // Needs two entries so the tail is never the head currently on the memory port.
  assign w_merge = w_store && (r_count >= CNT_W'(2)) &&
                   (r_addr[w_tail_last] == st_addr[ADDR_W-1:2]);
`else
  assign w_merge = 1'b0;
`endif

  assign st_ready = !w_full || w_merge;
  assign w_alloc  = w_store && !w_full && !w_merge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_head          <= r_head + PTR_W'(1);
        r_valid[r_head] <= 1'b0;
      end
      if (w_alloc) begin
        r_tail          <= r_tail + PTR_W'(1);
        r_valid[r_tail] <= 1'b1;
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= st_addr[ADDR_W-1:2];
      r_data[r_tail] <= w_aligned;
      r_we[r_tail]   <= st_we;
    end
`ifdef STORE_BUFFER_MERGE_EN
    else if (w_merge) begin
      for (int b = 0; b < 4; b++) begin
        if (st_we[b]) r_data[w_tail_last][8*b +: 8] <= w_aligned[8*b +: 8];
      end
      r_we[w_tail_last] <= r_we[w_tail_last] | st_we;
    end
`endif
  end

  assign mem_req   = (r_count != '0);
  assign mem_addr  = r_addr[r_head];
  assign mem_wdata = r_data[r_head];
  assign mem_we    = r_we[r_head];
  assign count     = r_count;

  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == ld_addr[ADDR_W-1:2])) ld_conflict = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly downstream of StoresControl in the execute/memory boundary of the 3-stage MIPS pipeline.
- Accepts a store (word address, rt data, byte write-enable mask) and performs lane alignment of the data.
- Queues stores in a small FIFO and drains them to the data memory over a valid/ready port, so memory stalls do not stall the pipeline until the buffer fills.
- Flags loads that hit a pending store word so the hazard unit can stall them.

Parameters:
DEPTH, 4, number of buffered stores (power of two, >=2)
ADDR_W, 32, byte address width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
st_valid  input  1  execute stage presents a store this cycle
st_ready  output  1  buffer can accept a new entry (not full)
st_addr  input  ADDR_W  byte address (ALUoutE)
st_data  input  32  unaligned rt register value
st_we  input  4  byte enables from StoresControl; bit3 = byte at addr 00 (big-endian)
mem_req  output  1  head entry valid toward data memory
mem_ready  input  1  memory accepts head this cycle
mem_addr  output  ADDR_W-2  word address of head
mem_wdata  output  32  lane-aligned head data
mem_we  output  4  head byte mask
ld_addr  input  ADDR_W  address of load in execute
ld_conflict  output  1  load word matches a pending entry
count  output  log2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst_n=0): head, tail and count cleared; all entry valid bits 0; mem_req=0, st_ready=1, ld_conflict=0. Asserting reset mid-drain discards all entries, including a head that is being presented.
- Push:
  - Occurs on a rising edge when st_valid=1 and st_ready=1 and st_we!=0.
  - st_valid with st_we=4'b0000 (non-store opcode) is ignored and never enqueued.
- Alignment at push:
  - we=1111 stores st_data.
  - we in {1100,0011} stores {2{st_data[15:0]}}.
  - Single-bit we stores {4{st_data[7:0]}}.
  - Stored mem_addr = st_addr[ADDR_W-1:2].
- Output port:
  - mem_req = (count!=0); mem_addr, mem_wdata and mem_we reflect the head entry.
  - These outputs come from registered state only; no combinational path from st_* to mem_*.
  - Earliest memory appearance is the cycle after the push.
- Pop:
  - Occurs on a rising edge with mem_req=1 and mem_ready=1.
  - While mem_req=1 and mem_ready=0, head outputs hold stable.
- Full/empty:
  - st_ready = (count!=DEPTH).
  - When full, push is refused even if a pop occurs in the same cycle; there is no same-cycle bypass.
  - When empty, mem_ready is ignored.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Order: entries drain strictly FIFO. Two stores to the same word remain separate entries unless the optional feature below is enabled.
- ld_conflict:
  - Combinational.
  - Set to 1 if any valid entry's word address equals ld_addr[ADDR_W-1:2]; 0 otherwise.
  - The store being pushed in the same cycle is not compared.
  - A matching head that is popping this cycle still counts as a conflict.

Optional Feature:
- Macro: STORE_BUFFER_MERGE_EN.
- Defined:
  - A push whose word address equals the tail entry's address merges into the tail instead of allocating, provided count>=2 (tail is not the head being presented).
  - Bytes with st_we set overwrite the tail data; tail mem_we |= st_we; count unchanged.
  - Merge is permitted while full, so st_ready=1 when full and a merge is possible.
- Undefined: no merging; every accepted store allocates an entry.

Test Plan:
- Reset with 2 entries pending, rst_n low mid-cycle -> immediately count=0, mem_req=0, st_ready=1.
- sb addr 0x00000103 data 0x000000AB, mem_ready=1 -> next cycle mem_req=1, mem_addr=0x40, mem_we=0001, mem_wdata=0xABABABAB; popped the following edge.
- sh addr 0x10 data 0x1234, then sw addr 0x20 data 0xDEADBEEF, mem_ready=0 -> count=2, head holds mem_we=1100 and wdata=0x12341234 stable; raising mem_ready drains sh then sw in order.
- mem_ready=0, push DEPTH=4 stores -> st_ready=0 and a 5th push is refused. Push and pop in the same cycle while full -> count goes to 3; the refused store is not written.
- Entries at words 0x40 and 0x41, ld_addr=0x104 -> ld_conflict=1; ld_addr=0x108 -> 0. st_valid with st_we=0000 -> count unchanged.
- With STORE_BUFFER_MERGE_EN: count=2, tail word 0x50 mask 1000, push sb addr 0x143 data 0x77 -> tail mask 1001, byte lane0=0x77, count stays 2.
